// File: rtl/etc2_rgb_decoder.sv
// Per-pixel ETC2 RGB / RGB-A1 texel decoder: one block, mode and pixel index in,
// one registered RGBA8 texel out a cycle later with a valid strobe.
module etc2_rgb_decoder (
  input  logic        sclk,
  input  logic        rsrt,
  input  logic        rtr,
  input  logic [2:0]  mode,
  input  logic [63:0] block,
  input  logic        flag_punchThrough,
  input  logic        aplha,
  input  logic [3:0]  pixIdx,
  output logic        color_rts,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [7:0]  a
);

  // Handshake: inputs are sampled on an edge with rtr=1; color_rts is high for
  // exactly the following cycle with r/g/b/a valid; outputs hold while rtr=0.

  function automatic logic [7:0] ext4(input logic [3:0] v);
    return {v, v};
  endfunction

  function automatic logic [7:0] ext5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] ext6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  function automatic logic [7:0] ext7(input logic [6:0] v);
    return {v, v[6]};
  endfunction

  function automatic logic [7:0] clamp14(input logic signed [13:0] v);
    if (v < 14'sd0)        return 8'd0;
    else if (v > 14'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  function automatic logic [7:0] add_sat(input logic [7:0] c, input logic signed [9:0] d);
    logic signed [13:0] s;
    s = $signed({6'd0, c}) + $signed({{4{d[9]}}, d});
    return clamp14(s);
  endfunction

  function automatic logic [7:0] mod_a(input logic [2:0] i);
    case (i)
      3'd0: return 8'd2;   3'd1: return 8'd5;   3'd2: return 8'd9;   3'd3: return 8'd13;
      3'd4: return 8'd18;  3'd5: return 8'd24;  3'd6: return 8'd33;  default: return 8'd47;
    endcase
  endfunction

  function automatic logic [7:0] mod_b(input logic [2:0] i);
    case (i)
      3'd0: return 8'd8;   3'd1: return 8'd17;  3'd2: return 8'd29;  3'd3: return 8'd42;
      3'd4: return 8'd60;  3'd5: return 8'd80;  3'd6: return 8'd106; default: return 8'd183;
    endcase
  endfunction

  function automatic logic [7:0] dist_tbl(input logic [2:0] i);
    case (i)
      3'd0: return 8'd3;   3'd1: return 8'd6;   3'd2: return 8'd11;  3'd3: return 8'd16;
      3'd4: return 8'd23;  3'd5: return 8'd32;  3'd6: return 8'd41;  default: return 8'd64;
    endcase
  endfunction

  function automatic logic [7:0] planar_ch(input logic [7:0] o, input logic [7:0] h,
                                           input logic [7:0] v, input logic [1:0] x,
                                           input logic [1:0] y);
    logic signed [13:0] so, dh, dv, acc;
    so  = $signed({6'd0, o});
    dh  = $signed({6'd0, h}) - so;
    dv  = $signed({6'd0, v}) - so;
    acc = $signed({12'd0, x}) * dh + $signed({12'd0, y}) * dv + (so <<< 2) + 14'sd2;
    return clamp14(acc >>> 2);
  endfunction

  logic [1:0]  px_x, px_y, idx;
  logic        is_diff, sub2, pt_diff, transparent;
  logic [2:0]  cw;
  logic [4:0]  d2_r, d2_g, d2_b;
  logic [23:0] base1, base2, sub_base;
  logic [7:0]  ma, mb;
  logic signed [9:0] id_off, pc_off;
  logic [23:0] t_c1, t_c2, h_c1, h_c2, pc_base;
  logic [11:0] h_c1_12, h_c2_12;
  logic [7:0]  td, hd;
  logic [23:0] id_rgb, th_rgb, pl_rgb, rgb_d;
  logic [7:0]  a_d;

  logic        color_rts_q;
  logic [7:0]  r_q, g_q, b_q, a_q;

  assign px_x = pixIdx[3:2];
  assign px_y = pixIdx[1:0];
  assign idx  = {block[{2'b01, pixIdx}], block[{2'b00, pixIdx}]};

  // Individual / differential base colours and per-pixel modifier
  assign is_diff = (mode == 3'd1);
  assign d2_r = block[63:59] + {{2{block[58]}}, block[58:56]};
  assign d2_g = block[55:51] + {{2{block[50]}}, block[50:48]};
  assign d2_b = block[47:43] + {{2{block[42]}}, block[42:40]};
  assign base1 = is_diff ? {ext5(block[63:59]), ext5(block[55:51]), ext5(block[47:43])}
                         : {ext4(block[63:60]), ext4(block[55:52]), ext4(block[47:44])};
  assign base2 = is_diff ? {ext5(d2_r), ext5(d2_g), ext5(d2_b)}
                         : {ext4(block[59:56]), ext4(block[51:48]), ext4(block[43:40])};
  assign sub2     = block[32] ? px_y[1] : px_x[1];
  assign sub_base = sub2 ? base2 : base1;
  assign cw       = sub2 ? block[36:34] : block[39:37];
  assign pt_diff  = flag_punchThrough & ~block[33] & is_diff;
  assign ma       = pt_diff ? 8'd0 : mod_a(cw);
  assign mb       = mod_b(cw);

  always_comb begin
    id_off = 10'sd0;
    case (idx)
      2'd0:    id_off = $signed({2'b00, ma});
      2'd1:    id_off = $signed({2'b00, mb});
      2'd2:    id_off = -$signed({2'b00, ma});
      default: id_off = -$signed({2'b00, mb});
    endcase
  end

  // T and H paint colours
  assign t_c1 = {ext4({block[60:59], block[57:56]}), ext4(block[55:52]), ext4(block[51:48])};
  assign t_c2 = {ext4(block[47:44]), ext4(block[43:40]), ext4(block[39:36])};
  assign h_c1_12 = {block[62:59], block[58:56], block[52], block[51], block[49:47]};
  assign h_c2_12 = {block[46:43], block[42:39], block[38:35]};
  assign h_c1 = {ext4(h_c1_12[11:8]), ext4(h_c1_12[7:4]), ext4(h_c1_12[3:0])};
  assign h_c2 = {ext4(h_c2_12[11:8]), ext4(h_c2_12[7:4]), ext4(h_c2_12[3:0])};
  assign td = dist_tbl({block[35:34], block[32]});
  assign hd = dist_tbl({block[34], block[32], (h_c1_12 >= h_c2_12)});

  always_comb begin
    pc_base = 24'd0;
    pc_off  = 10'sd0;
    if (mode == 3'd2) begin
      case (idx)
        2'd0:    begin pc_base = t_c1; pc_off = 10'sd0;               end
        2'd1:    begin pc_base = t_c2; pc_off = $signed({2'b00, td}); end
        2'd2:    begin pc_base = t_c2; pc_off = 10'sd0;               end
        default: begin pc_base = t_c2; pc_off = -$signed({2'b00, td}); end
      endcase
    end else begin
      pc_base = idx[1] ? h_c2 : h_c1;
      pc_off  = idx[0] ? -$signed({2'b00, hd}) : $signed({2'b00, hd});
    end
  end

  assign id_rgb = {add_sat(sub_base[23:16], id_off), add_sat(sub_base[15:8], id_off),
                   add_sat(sub_base[7:0], id_off)};
  assign th_rgb = {add_sat(pc_base[23:16], pc_off), add_sat(pc_base[15:8], pc_off),
                   add_sat(pc_base[7:0], pc_off)};
  assign pl_rgb = {planar_ch(ext6(block[62:57]), ext6({block[38:34], block[32]}),
                             ext6(block[18:13]), px_x, px_y),
                   planar_ch(ext7({block[56], block[54:49]}), ext7(block[31:25]),
                             ext7(block[12:6]), px_x, px_y),
                   planar_ch(ext6({block[48], block[44:43], block[41:39]}), ext6(block[24:19]),
                             ext6(block[5:0]), px_x, px_y)};

  assign transparent = flag_punchThrough & aplha & ~block[33] & (idx == 2'd2) &
                       (mode == 3'd1 || mode == 3'd2 || mode == 3'd3);

  always_comb begin
    rgb_d = pl_rgb;
    case (mode)
      3'd0, 3'd1: rgb_d = id_rgb;
      3'd2, 3'd3: rgb_d = th_rgb;
      default:    rgb_d = pl_rgb;
    endcase
    a_d = 8'hFF;
    if (transparent) begin
      rgb_d = 24'd0;
      a_d   = 8'h00;
    end
  end

  always_ff @(posedge sclk) begin
    if (rsrt) begin
      color_rts_q <= 1'b0;
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
      a_q <= 8'd0;
    end else begin
      color_rts_q <= rtr;
      if (rtr) begin
        r_q <= rgb_d[23:16];
        g_q <= rgb_d[15:8];
        b_q <= rgb_d[7:0];
        a_q <= a_d;
      end
    end
  end

  assign color_rts = color_rts_q;
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign a = a_q;

endmodule

// File: tb/tb_etc2_rgb_decoder.sv
// Bench for etc2_rgb_decoder: vector table with an integer reference decoder,
// streamed through the DUT with a scoreboard queue, plus reset/hold sequences.
module tb_etc2_rgb_decoder;

  logic        sclk, rsrt, rtr;
  logic [2:0]  mode;
  logic [63:0] block;
  logic        flag_punchThrough, aplha;
  logic [3:0]  pixIdx;
  logic        color_rts;
  logic [7:0]  r, g, b, a;

  typedef struct packed {
    logic [63:0] blk;
    logic [2:0]  md;
    logic        pt;
    logic        al;
    logic [3:0]  pix;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic        exp_vld;
  logic [31:0] last_exp;
  int          n_vec, n_err;

  int mod_a_t [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
  int mod_b_t [8] = '{8, 17, 29, 42, 60, 80, 106, 183};
  int dist_t  [8] = '{3, 6, 11, 16, 23, 32, 41, 64};

  etc2_rgb_decoder dut (
    .sclk(sclk), .rsrt(rsrt), .rtr(rtr), .mode(mode), .block(block),
    .flag_punchThrough(flag_punchThrough), .aplha(aplha), .pixIdx(pixIdx),
    .color_rts(color_rts), .r(r), .g(g), .b(b), .a(a)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic int cl(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction
  function automatic int e4(input int v); return v * 17; endfunction
  function automatic int e5(input int v); return (v << 3) | (v >> 2); endfunction
  function automatic int e6(input int v); return (v << 2) | (v >> 4); endfunction
  function automatic int e7(input int v); return (v << 1) | (v >> 6); endfunction

  function automatic logic [31:0] golden(input logic [63:0] blk, input logic [2:0] md,
                                         input logic pt, input logic al, input logic [3:0] pix);
    int p, x, y, idx, cw, av, bv, off, d, k, hi, v5, dl, aa, sub2;
    int c1[3], c2[3], o[3], h[3], v[3], res[3];
    p = pix; x = p / 4; y = p % 4;
    idx = 2 * blk[p + 16] + blk[p];
    aa = 255;
    if (md <= 1) begin
      for (int ch = 0; ch < 3; ch++) begin
        hi = 63 - 8 * ch;
        if (md == 0) begin
          c1[ch] = e4(blk[hi -: 4]);
          c2[ch] = e4(blk[hi - 4 -: 4]);
        end else begin
          v5 = blk[hi -: 5];
          dl = blk[hi - 5 -: 3];
          if (dl > 3) dl = dl - 8;
          c1[ch] = e5(v5);
          c2[ch] = e5((v5 + dl) & 31);
        end
      end
      sub2 = blk[32] ? (y >= 2) : (x >= 2);
      cw = sub2 ? blk[36:34] : blk[39:37];
      av = (md == 1 && pt && !blk[33]) ? 0 : mod_a_t[cw];
      bv = mod_b_t[cw];
      case (idx)
        0: off = av;
        1: off = bv;
        2: off = -av;
        default: off = -bv;
      endcase
      for (int ch = 0; ch < 3; ch++) res[ch] = cl((sub2 ? c2[ch] : c1[ch]) + off);
    end else if (md == 2) begin
      c1 = '{e4({blk[60:59], blk[57:56]}), e4(blk[55:52]), e4(blk[51:48])};
      c2 = '{e4(blk[47:44]), e4(blk[43:40]), e4(blk[39:36])};
      d = dist_t[{blk[35:34], blk[32]}];
      for (int ch = 0; ch < 3; ch++)
        case (idx)
          0: res[ch] = c1[ch];
          1: res[ch] = cl(c2[ch] + d);
          2: res[ch] = c2[ch];
          default: res[ch] = cl(c2[ch] - d);
        endcase
    end else if (md == 3) begin
      c1 = '{int'(blk[62:59]), int'({blk[58:56], blk[52]}), int'({blk[51], blk[49:47]})};
      c2 = '{int'(blk[46:43]), int'(blk[42:39]), int'(blk[38:35])};
      k = ((c1[0] * 256 + c1[1] * 16 + c1[2]) >= (c2[0] * 256 + c2[1] * 16 + c2[2])) ? 1 : 0;
      d = dist_t[blk[34] * 4 + blk[32] * 2 + k];
      for (int ch = 0; ch < 3; ch++)
        case (idx)
          0: res[ch] = cl(e4(c1[ch]) + d);
          1: res[ch] = cl(e4(c1[ch]) - d);
          2: res[ch] = cl(e4(c2[ch]) + d);
          default: res[ch] = cl(e4(c2[ch]) - d);
        endcase
    end else begin
      o = '{e6(blk[62:57]), e7({blk[56], blk[54:49]}), e6({blk[48], blk[44:43], blk[41:39]})};
      h = '{e6({blk[38:34], blk[32]}), e7(blk[31:25]), e6(blk[24:19])};
      v = '{e6(blk[18:13]), e7(blk[12:6]), e6(blk[5:0])};
      for (int ch = 0; ch < 3; ch++)
        res[ch] = cl((x * (h[ch] - o[ch]) + y * (v[ch] - o[ch]) + 4 * o[ch] + 2) >>> 2);
    end
    if (pt && al && md >= 1 && md <= 3 && !blk[33] && idx == 2) begin
      res = '{0, 0, 0};
      aa = 0;
    end
    if (!al) aa = 255;
    return {8'(res[0]), 8'(res[1]), 8'(res[2]), 8'(aa)};
  endfunction

  function automatic vec_t mk(input logic [63:0] blk, input logic [2:0] md, input logic pt,
                              input logic al, input logic [3:0] pix, input logic [31:0] e);
    vec_t t;
    t.blk = blk; t.md = md; t.pt = pt; t.al = al; t.pix = pix; t.exp = e;
    return t;
  endfunction

  function automatic vec_t gv(input logic [63:0] blk, input logic [2:0] md, input logic pt,
                              input logic al, input logic [3:0] pix);
    return mk(blk, md, pt, al, pix, golden(blk, md, pt, al, pix));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t t, input logic do_rtr);
    block = t.blk; mode = t.md; flag_punchThrough = t.pt; aplha = t.al; pixIdx = t.pix;
    rtr = do_rtr;
    if (do_rtr && !rsrt) exp_q.push_back(t.exp);
  endtask

  // One clock: note whether a texel is owed, then check outputs on the falling edge.
  task automatic tick();
    @(posedge sclk);
    exp_vld = rtr && !rsrt;
    @(negedge sclk);
    check("color_rts", {31'd0, color_rts}, {31'd0, exp_vld});
    if (color_rts) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL texel: unexpected valid, got %h, expected none", {r, g, b, a});
      end else begin
        last_exp = exp_q.pop_front();
        check("texel", {r, g, b, a}, last_exp);
      end
    end
  endtask

  localparam logic [63:0] BLK_PL  = 64'h5f91045b86f674a5;
  localparam logic [63:0] BLK_ID  = 64'h47582425E600411B;
  localparam logic [63:0] BLK_DF  = 64'h4554453200fef0e0;
  localparam logic [63:0] BLK_DFP = 64'h4554453000fef0e0;
  localparam logic [63:0] BLK_T   = 64'hf387b98341197667;
  localparam logic [63:0] BLK_TP  = 64'hf387b98141197667;
  localparam logic [63:0] BLK_H   = 64'h75f95d4273003010;
  localparam logic [63:0] BLK_CL  = 64'hF0F0F0FCFF00FFFF;

  initial begin
    n_vec = 0; n_err = 0; exp_vld = 1'b0; last_exp = 32'd0;
    rsrt = 1'b1;
    apply(mk(BLK_PL, 3'd4, 1'b0, 1'b1, 4'd0, 32'd0), 1'b1);
    tick();
    tick();
    check("reset_rgba", {r, g, b, a}, 32'd0);

    vecs.push_back(mk(BLK_PL, 3'd4, 1'b0, 1'b1, 4'd0, 32'hBE9182FF));
    vecs.push_back(mk(BLK_ID, 3'd0, 1'b0, 1'b1, 4'd0, 32'h556633FF));
    vecs.push_back(mk(BLK_CL, 3'd0, 1'b0, 1'b1, 4'd0, 32'hFFFFFFFF));
    vecs.push_back(mk(BLK_CL, 3'd0, 1'b0, 1'b1, 4'd5, 32'hFFFFFFFF));
    vecs.push_back(mk(BLK_CL, 3'd0, 1'b0, 1'b1, 4'd8, 32'h000000FF));
    vecs.push_back(mk(BLK_CL, 3'd0, 1'b0, 1'b1, 4'd15, 32'h000000FF));
    vecs.push_back(mk(BLK_TP, 3'd2, 1'b1, 1'b1, 4'd3, 32'h00000000));
    vecs.push_back(mk(BLK_TP, 3'd2, 1'b1, 1'b0, 4'd3, 32'hBB9988FF));
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(gv(BLK_PL, 3'd4, 1'b0, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_ID, 3'd0, 1'b0, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_DF, 3'd1, 1'b0, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_T,  3'd2, 1'b0, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_H,  3'd3, 1'b0, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_DFP, 3'd1, 1'b1, 1'b1, 4'(i)));
      vecs.push_back(gv(BLK_TP, 3'd2, 1'b1, 1'b1, 4'(i)));
    end
    vecs.push_back(gv(BLK_PL, 3'd5, 1'b0, 1'b1, 4'd7));
    vecs.push_back(gv(BLK_PL, 3'd7, 1'b1, 1'b1, 4'd13));
    for (int i = 0; i < 48; i++)
      vecs.push_back(gv({$urandom(), $urandom()}, 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15))));

    rsrt = 1'b0;
    foreach (vecs[i]) begin
      if (i > 8 && $urandom_range(0, 5) == 0) begin
        rtr = 1'b0;
        tick();
      end
      apply(vecs[i], 1'b1);
      tick();
    end
    rtr = 1'b0;
    tick();
    check("hold_rgba", {r, g, b, a}, last_exp);

    apply(vecs[1], 1'b1);
    tick();
    rsrt = 1'b1;
    apply(vecs[2], 1'b1);
    tick();
    check("reset_midrun_rgba", {r, g, b, a}, 32'd0);
    rsrt = 1'b0;
    apply(vecs[0], 1'b1);
    tick();
    rtr = 1'b0;
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/etc2_rgb_decoder.md
Name: etc2_rgb_decoder

Overview:
Per-pixel ETC2 RGB / RGB-A1 texel decoder. It takes one 64-bit compressed 4x4 block, an externally detected block mode and a 4-bit pixel index. It returns one registered RGBA8 texel with a valid strobe. It sits downstream of the block mode detector, which drives `rtr` and `mode`, and upstream of the texel write-back logic.

Parameters:
None. All widths are fixed by the ETC2 format.

Ports:
sclk  input  1  clock; all logic on the rising edge
rsrt  input  1  reset, synchronous, active-high
rtr  input  1  request: decode the pixel selected by the current `block`, `mode` and `pixIdx`
mode  input  3  0=individual, 1=differential, 2=T, 3=H, 4=planar; 5-7 reserved, decoded as planar
block  input  64  compressed block, big-endian (bit 63 = first stream bit)
flag_punchThrough  input  1  1 = RGB-A1 (punch-through) format
aplha  input  1  alpha enable; 0 forces a=8'hFF
pixIdx  input  4  pixel index, column-major: x=pixIdx[3:2], y=pixIdx[1:0]
color_rts  output  1  decoded texel valid
r  output  8  red
g  output  8  green
b  output  8  blue
a  output  8  alpha

Behaviour:
- Reset (`rsrt`=1 at an edge): `color_rts`, `r`, `g`, `b`, `a` all go to 0 on that edge.
  - Reset overrides a concurrent `rtr`.
  - A decode in flight is discarded.
- Latency and handshake:
  - Inputs are sampled on the edge where `rtr`=1.
  - The result appears after that edge: `color_rts`=1 for exactly the following cycle, with `r`/`g`/`b`/`a` registered.
  - If `rtr` is held high, a new texel is produced every cycle (throughput 1/clk).
  - When `rtr`=0, `color_rts` drops to 0 on the next edge; `r`/`g`/`b`/`a` hold their last value.
- Pixel index bits: lsb = `block[pixIdx]`, msb = `block[pixIdx+16]`; idx = {msb,lsb}.
- Colour expansion to 8 bits:
  - 4b: v*17.
  - 5b: {v,v[4:2]}.
  - 6b: {v,v[5:4]}.
  - 7b: {v,v[6]}.
  - All adds and subtracts clamp to 0..255.
- Individual (`mode`=0):
  - Base 1 = 4-bit `block[63:60]` (R), `[55:52]` (G), `[47:44]` (B).
  - Base 2 = 4-bit `[59:56]` (R), `[51:48]` (G), `[43:40]` (B).
- Differential (`mode`=1):
  - Base 1 = 5-bit `[63:59]` (R), `[55:51]` (G), `[47:43]` (B).
  - Base 2 = base 1 + signed 3-bit delta `[58:56]` / `[50:48]` / `[42:40]` (5-bit wrap).
- Individual and differential common rules:
  - Codeword 1 = `[39:37]`, codeword 2 = `[36:34]`, flip = `[32]`.
  - Sub-block 2 when (flip=0 and x>=2) or (flip=1 and y>=2); otherwise sub-block 1.
  - Modifier pairs (a,b): {2,8},{5,17},{9,29},{13,42},{18,60},{24,80},{33,106},{47,183}.
  - idx 0:+a, 1:+b, 2:-a, 3:-b, added to each channel.
- T (`mode`=2):
  - C1 = R {[60:59],[57:56]}, G [55:52], B [51:48].
  - C2 = R [47:44], G [43:40], B [39:36].
  - Distance index = {[35:34],[32]}; distance table {3,6,11,16,23,32,41,64}.
  - Paint colours: idx 0=C1, 1=C2+d, 2=C2, 3=C2-d.
- H (`mode`=3):
  - C1 = R [62:59], G {[58:56],[52]}, B {[51],[49:47]}.
  - C2 = R [46:43], G [42:39], B [38:35].
  - Distance index = {[34],[32],(C1_12bit >= C2_12bit)}, where Cn_12bit = {R,G,B} 4-bit packed.
  - Paint colours: idx 0=C1+d, 1=C1-d, 2=C2+d, 3=C2-d.
- Planar (`mode`=4):
  - O = R [62:57] (6b), G {[56],[54:49]} (7b), B {[48],[44:43],[41:39]} (6b).
  - H = R {[38:34],[32]}, G [31:25], B [24:19].
  - V = R [18:13], G [12:6], B [5:0].
  - All expanded to 8 bits before use.
  - Channel = clamp((x*(H-O) + y*(V-O) + 4*O + 2) >> 2), computed signed with at least 11 bits.
  - Planar ignores the punch-through rules below.
- Punch-through (`flag_punchThrough`=1), differential/T/H only:
  - Differential with opaque bit `[33]`=0: modifier table a-values become 0, and idx 2 is transparent.
  - T/H with `[33]`=0: idx 2 is transparent.
  - A transparent pixel outputs r=g=b=a=0 (only when `aplha`=1).
- Alpha: a=8'hFF for all opaque pixels; a=8'hFF always when `aplha`=0.

Test Plan:
1. Reset: `rsrt`=1 for 2 cycles with `rtr`=1 -> `color_rts`=0, r/g/b/a=0; `color_rts` first rises one cycle after `rtr` is sampled with `rsrt`=0.
2. Planar: `block`=64'h5f91045b86f674a5, `mode`=4, `pixIdx`=0 -> (190,145,130,255); then sweep `pixIdx` 0..15 against the golden ETC2 model.
3. Individual: `block`=64'h47582425E600411B, `mode`=0, `pixIdx`=0 -> (85,102,51,255); sweep all 16 pixels.
4. Differential/T/H: 64'h4554453200fef0e0 (`mode`=1), 64'hf387b98341197667 (`mode`=2), 64'h75f95d4273003010 (`mode`=3), all 16 pixels -> match golden model; include clamp at 0 and at 255.
5. Punch-through: `flag_punchThrough`=1, `aplha`=1, T block with bit33=0 and a pixel with idx 2 -> (0,0,0,0); same pixel with `aplha`=0 -> a=255.
6. Streaming: `rtr` held high while `pixIdx` changes every cycle -> one valid texel per cycle in order; deassert `rtr` -> `color_rts`=0 on the next cycle.
